// File: rtl/alu_sequencer_if.sv
// Instruction, ALU and result signals that connect the sequencer to its
// upstream issuer and to the 8-bit ALU.
interface alu_sequencer_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  alu_op_code;
  logic [7:0]  alu_data1;
  logic [7:0]  alu_data2;
  logic [7:0]  alu_result;
  logic        alu_zero;
  logic        alu_overflow;
  logic        alu_done;
  logic        result_valid;
  logic [7:0]  result;
  logic        result_zero;
  logic        result_overflow;
  logic        error;
  logic        busy;

  modport master (
    input  instr_valid, instr, alu_result, alu_zero, alu_overflow, alu_done,
    output instr_ready, alu_op_code, alu_data1, alu_data2,
           result_valid, result, result_zero, result_overflow, error, busy
  );

  modport slave (
    output instr_valid, instr, alu_result, alu_zero, alu_overflow, alu_done,
    input  instr_ready, alu_op_code, alu_data1, alu_data2,
           result_valid, result, result_zero, result_overflow, error, busy
  );
endinterface

// File: rtl/alu_sequencer.sv
// Instruction sequencer in front of the 8-bit ALU: owns a 4x8 register file,
// issues one instruction at a time and writes the ALU result back.
module alu_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clock,
  input  logic                 reset_n,
  alu_sequencer_if.master      bus,
  input  logic [1:0]           rd_addr,
  output logic [7:0]           rd_data
);

  localparam int unsigned DW   = 8;
  localparam int unsigned OPW  = 4;
  localparam int unsigned RAW  = 2;
  localparam int unsigned NREG = 4;
  localparam int unsigned CW   = 4;

  localparam logic [OPW-1:0] OP_NOOP = 4'b0000;
  localparam logic [OPW-1:0] OP_ADD  = 4'b0001;
  localparam logic [OPW-1:0] OP_SUB  = 4'b0010;
  localparam logic [OPW-1:0] OP_AND  = 4'b0110;
  localparam logic [OPW-1:0] OP_OR   = 4'b0111;
  localparam logic [OPW-1:0] OP_ZT   = 4'b1001;
  localparam logic [OPW-1:0] OP_GT   = 4'b1010;
  localparam logic [OPW-1:0] OP_EQ   = 4'b1011;
  localparam logic [OPW-1:0] OP_LT   = 4'b1100;
  localparam logic [OPW-1:0] OP_LDI  = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t         state;
  logic [DW-1:0]  regs [NREG];
  logic [CW-1:0]  cnt;
  logic [RAW-1:0] dst_q;

  logic [OPW-1:0] op;
  logic [RAW-1:0] dst, src1, src2;
  logic [DW-1:0]  imm;
  logic           op_alu, op_ldi;

  assign op   = bus.instr[15:12];
  assign dst  = bus.instr[11:10];
  assign src1 = bus.instr[9:8];
  assign src2 = bus.instr[7:6];
  assign imm  = bus.instr[7:0];

  // Opcode classification; anything not listed is illegal.
  always_comb begin
    op_alu = 1'b0;
    op_ldi = 1'b0;
    case (op)
      OP_NOOP, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ZT, OP_GT, OP_EQ, OP_LT: op_alu = 1'b1;
      OP_LDI:                     op_ldi = 1'b1;
      default: ;
    endcase
  end

  assign bus.instr_ready = (state == S_IDLE);
  assign bus.busy        = (state != S_IDLE);
  assign rd_data         = regs[rd_addr];

  // alu_done is a sticky level from the ALU, so it is only trusted in WAIT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state               <= S_IDLE;
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
      cnt                 <= '0;
      dst_q               <= '0;
      bus.alu_op_code     <= OP_NOOP;
      bus.alu_data1       <= '0;
      bus.alu_data2       <= '0;
      bus.result_valid    <= 1'b0;
      bus.error           <= 1'b0;
      bus.result          <= '0;
      bus.result_zero     <= 1'b0;
      bus.result_overflow <= 1'b0;
    end else begin
      bus.result_valid <= 1'b0;
      bus.error        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            if (op_alu) begin
              bus.alu_op_code <= op;
              bus.alu_data1   <= regs[src1];
              bus.alu_data2   <= regs[src2];
              dst_q           <= dst;
              state           <= S_ISSUE;
            end else if (op_ldi) begin
              regs[dst]           <= imm;
              bus.result          <= imm;
              bus.result_zero     <= 1'b0;
              bus.result_overflow <= 1'b0;
              bus.result_valid    <= 1'b1;
            end else begin
              bus.result          <= '0;
              bus.result_zero     <= 1'b0;
              bus.result_overflow <= 1'b0;
              bus.result_valid    <= 1'b1;
              bus.error           <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.alu_done) begin
            regs[dst_q]         <= bus.alu_result;
            bus.result          <= bus.alu_result;
            bus.result_zero     <= bus.alu_zero;
            bus.result_overflow <= bus.alu_overflow;
            bus.result_valid    <= 1'b1;
            bus.alu_op_code     <= OP_NOOP;
            bus.alu_data1       <= '0;
            bus.alu_data2       <= '0;
            state               <= S_IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            bus.result          <= '0;
            bus.result_zero     <= 1'b0;
            bus.result_overflow <= 1'b0;
            bus.result_valid    <= 1'b1;
            bus.error           <= 1'b1;
            bus.alu_op_code     <= OP_NOOP;
            bus.alu_data1       <= '0;
            bus.alu_data2       <= '0;
            state               <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed, table-driven bench for alu_sequencer with a small registered ALU stub.
module tb_alu_sequencer;

  localparam int unsigned TMO = 15;

  logic       clock;
  logic       reset_n;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  bit         hold;

  alu_sequencer_if bus ();

  alu_sequencer #(.TIMEOUT(TMO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int rv_count = 0;

  // ALU stub: samples a non-NOOP op on a clock edge; done stays high afterwards.
  logic [7:0] m_res;
  logic       m_z, m_o, m_done;

  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'b0001: return {1'b0, a} + {1'b0, b};
      4'b0010: return {1'b0, a} + {1'b0, ~b} + 9'd1;
      4'b0110: return {1'b0, a & b};
      4'b0111: return {1'b0, a | b};
      4'b1001: return {8'd0, (a == 8'd0)};
      4'b1010: return {8'd0, (a > b)};
      4'b1011: return {8'd0, (a == b)};
      4'b1100: return {8'd0, (a < b)};
      default: return 9'd0;
    endcase
  endfunction

  initial begin
    m_res = '0; m_z = 1'b0; m_o = 1'b0; m_done = 1'b0;
  end

  always @(posedge clock) begin
    if (bus.alu_op_code != 4'd0) begin
      logic [8:0] t;
      t = alu_f(bus.alu_op_code, bus.alu_data1, bus.alu_data2);
      m_res  <= t[7:0];
      m_o    <= t[8];
      m_z    <= (t[7:0] == 8'd0);
      m_done <= 1'b1;
    end
  end

  assign bus.alu_result   = m_res;
  assign bus.alu_zero     = m_z;
  assign bus.alu_overflow = m_o;
  assign bus.alu_done     = m_done & ~hold;

  always @(posedge clock) if (bus.result_valid) rv_count++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] ins);
    @(negedge clock);
    chk("instr_ready_before_accept", 32'(bus.instr_ready), 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(posedge clock);
    #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_rv(output int lat);
    lat = 0;
    while (!bus.result_valid && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk("result_valid_seen", 32'(bus.result_valid), 32'd1);
  endtask

  task automatic chk_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    chk(name, 32'(rd_data), 32'(exp));
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  res;
    logic        z;
    logic        o;
    logic        e;
    int          lat;
    logic [7:0]  reg_v;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  initial begin
    int lat;
    logic [15:0] ins;

    vecs[0]  = '{16'hF47F, 8'h7F, 1'b0, 1'b0, 1'b0, 0, 8'h7F}; // LDI R1,7F
    vecs[1]  = '{16'hF801, 8'h01, 1'b0, 1'b0, 1'b0, 0, 8'h01}; // LDI R2,01
    vecs[2]  = '{16'h1D80, 8'h80, 1'b0, 1'b0, 1'b0, 2, 8'h80}; // ADD R3=R1+R2
    vecs[3]  = '{16'hF0FF, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 8'hFF}; // LDI R0,FF
    vecs[4]  = '{16'hF401, 8'h01, 1'b0, 1'b0, 1'b0, 0, 8'h01}; // LDI R1,01
    vecs[5]  = '{16'h1840, 8'h00, 1'b1, 1'b1, 1'b0, 2, 8'h00}; // ADD R2=R0+R1
    vecs[6]  = '{16'h2D40, 8'h00, 1'b1, 1'b1, 1'b0, 2, 8'h00}; // SUB R3=R1-R1
    vecs[7]  = '{16'hAC40, 8'h01, 1'b0, 1'b0, 1'b0, 2, 8'h01}; // GT R3=R0>R1
    vecs[8]  = '{16'hCC40, 8'h00, 1'b1, 1'b0, 1'b0, 2, 8'h00}; // LT R3=R0<R1
    vecs[9]  = '{16'hBD40, 8'h01, 1'b0, 1'b0, 1'b0, 2, 8'h01}; // EQ R3=R1==R1
    vecs[10] = '{16'h9E00, 8'h01, 1'b0, 1'b0, 1'b0, 2, 8'h01}; // ZT R3=(R2==0)
    vecs[11] = '{16'hF0F0, 8'hF0, 1'b0, 1'b0, 1'b0, 0, 8'hF0}; // LDI R0,F0
    vecs[12] = '{16'hF43C, 8'h3C, 1'b0, 1'b0, 1'b0, 0, 8'h3C}; // LDI R1,3C
    vecs[13] = '{16'h6840, 8'h30, 1'b0, 1'b0, 1'b0, 2, 8'h30}; // AND R2=R0&R1
    vecs[14] = '{16'h7C40, 8'hFC, 1'b0, 1'b0, 1'b0, 2, 8'hFC}; // OR R3=R0|R1
    vecs[15] = '{16'h3C40, 8'h00, 1'b0, 1'b0, 1'b1, 0, 8'hFC}; // illegal 0011
    vecs[16] = '{16'hD840, 8'h00, 1'b0, 1'b0, 1'b1, 0, 8'h30}; // illegal 1101

    hold = 1'b0;
    reset_n = 1'b0;
    rd_addr = 2'd0;
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_instr_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result_valid", 32'(bus.result_valid), 32'd0);
    chk("rst_alu_op_code", 32'(bus.alu_op_code), 32'd0);
    chk("rst_alu_data", 32'({bus.alu_data1, bus.alu_data2}), 32'd0);
    chk("rst_result", 32'({bus.result, bus.result_zero, bus.result_overflow, bus.error}), 32'd0);
    for (int r = 0; r < 4; r++) chk_reg("rst_reg", 2'(r), 8'h00);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      send(vecs[i].instr);
      wait_rv(lat);
      chk("latency", 32'(lat), 32'(vecs[i].lat));
      chk("result", 32'(bus.result), 32'(vecs[i].res));
      chk("result_zero", 32'(bus.result_zero), 32'(vecs[i].z));
      chk("result_overflow", 32'(bus.result_overflow), 32'(vecs[i].o));
      chk("error", 32'(bus.error), 32'(vecs[i].e));
      chk_reg("dst_reg", vecs[i].instr[11:10], vecs[i].reg_v);
    end

    // All registers intact after illegal ops; pulse lasts one cycle.
    chk_reg("post_illegal_r0", 2'd0, 8'hF0);
    chk_reg("post_illegal_r1", 2'd1, 8'h3C);
    chk_reg("post_illegal_r2", 2'd2, 8'h30);
    chk_reg("post_illegal_r3", 2'd3, 8'hFC);
    chk("illegal_ready", 32'(bus.instr_ready), 32'd1);
    @(posedge clock); #1;
    chk("illegal_pulse_end", 32'({bus.result_valid, bus.error}), 32'd0);

    // Timeout: ALU never reports done.
    hold = 1'b1;
    ins = 16'h1C40;  // ADD R3=R0+R1
    send(ins);
    @(posedge clock); #1;
    chk("tmo_busy", 32'(bus.busy), 32'd1);
    chk("tmo_op_issued", 32'(bus.alu_op_code), 32'd1);
    chk("tmo_data1", 32'(bus.alu_data1), 32'hF0);
    wait_rv(lat);
    chk("tmo_latency", 32'(lat + 1), 32'(TMO + 1));
    chk("tmo_error", 32'(bus.error), 32'd1);
    chk("tmo_result", 32'({bus.result, bus.result_zero, bus.result_overflow}), 32'd0);
    chk("tmo_op_noop", 32'(bus.alu_op_code), 32'd0);
    chk("tmo_data_zero", 32'({bus.alu_data1, bus.alu_data2}), 32'd0);
    chk("tmo_ready", 32'(bus.instr_ready), 32'd1);
    chk_reg("tmo_dst_kept", 2'd3, 8'hFC);
    @(posedge clock); #1;
    chk("tmo_pulse_end", 32'({bus.result_valid, bus.error}), 32'd0);

    // Reset while in WAIT drops the instruction.
    send(ins);
    repeat (4) @(posedge clock);
    #1;
    chk("wait_busy", 32'(bus.busy), 32'd1);
    lat = rv_count;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus.instr_ready), 32'd1);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_op", 32'(bus.alu_op_code), 32'd0);
    chk("midrst_data", 32'({bus.alu_data1, bus.alu_data2}), 32'd0);
    chk("midrst_result", 32'({bus.result_valid, bus.error, bus.result}), 32'd0);
    chk_reg("midrst_r3", 2'd3, 8'h00);
    chk_reg("midrst_r0", 2'd0, 8'h00);
    repeat (2) @(negedge clock);
    hold = 1'b0;
    reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk("midrst_no_result", 32'(rv_count), 32'(lat));
    chk("midrst_ready_after", 32'(bus.instr_ready), 32'd1);
    chk_reg("midrst_r3_after", 2'd3, 8'h00);

    // Still functional after reset.
    send(16'hF405);  // LDI R1,05
    wait_rv(lat);
    send(16'hF803);  // LDI R2,03
    wait_rv(lat);
    send(16'h1D80);  // ADD R3=R1+R2
    wait_rv(lat);
    chk("post_rst_lat", 32'(lat), 32'd2);
    chk("post_rst_result", 32'(bus.result), 32'h08);
    chk_reg("post_rst_r3", 2'd3, 8'h08);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
